masked_and_pipe: RTL and testbench
==================================

# masked_and_pipe

Parametrised d-share masked AND gadget for the masked-cipher datapath. It is the generalised successor of the fixed 2-share, 8-bit gadget: WIDTH and SHARES are configurable, a linear XOR mode is added, and a valid/ready handshake with backpressure is added. Operands are zero-sum refreshed, every cross-share product is masked with fresh randomness, and the products are compressed back to SHARES output shares over a 3-stage pipeline.

## Interface
- WIDTH, 8: bits per share.
- SHARES, 2: number of shares d, legal range 2..4. Elaboration error outside this range.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  pipeline can accept; equals !stall.
- op  in  1  0 = AND, 1 = XOR.
- a  in  SHARES*WIDTH  operand A shares; share i is [i*WIDTH +: WIDTH].
- b  in  SHARES*WIDTH  operand B shares, same packing as a.
- r_ref  in  2*(SHARES-1)*WIDTH  refresh randomness. Words 0..d-2 refresh A; words d-1..2d-3 refresh B.
- r_mul  in  SHARES*SHARES*WIDTH  product masks; word m = i*SHARES+j masks a_i & b_j.
- out_valid  out  1  c holds a result.
- out_ready  in  1  downstream accepts.
- c  out  SHARES*WIDTH  result shares. XOR of all shares equals (XOR of a) op (XOR of b).

## Operation
- Accept: a transaction is accepted on a cycle with in_valid && in_ready. a, b, op, r_ref and r_mul are sampled together; randomness is never reused across transactions.
- Stall: stall = out_valid && !out_ready. While stalled, every stage register and valid bit holds. There is no bubble collapse: the pipeline advances as one unit.
- Stage 1, refresh, registered:
  - a'_i = a_i ^ ra_i for i < d-1.
  - a'_{d-1} = a_{d-1} ^ XOR of all ra_i.
  - b' is formed the same way with rb.
  - r_mul and op are registered alongside.
- Stage 2, AND mode:
  - p_ij = (a'_i & b'_j) ^ r_ij, all d² terms, registered.
  - Mask compressions are also registered: k_s = XOR of r_m over all m with (m mod (d-1)) == s-1, for s = 1..d-1.
- Stage 2, XOR mode:
  - p_ii = a'_i ^ b'_i; every other p_ij = 0.
  - k_s = 0.
  - r_mul is ignored.
- Stage 3, output, registered:
  - AND mode: c_0 = XOR of all p_ij; c_s = k_s.
  - XOR mode: c_i = p_ii.
- Arithmetic: all operations are bitwise over WIDTH bits. There is no carry and no width growth.
- Reset: v1, v2, v3 (= out_valid) clear to 0. All data registers, including c, clear to 0. in_ready is 1 once rst_n is high.
- Reset mid-operation: in-flight transactions are discarded with no output. An input presented during the reset cycle is not accepted.
- Simultaneous accept and output: allowed every cycle while out_ready = 1, giving full throughput.

## Timing
- Latency is 3 cycles from accept to out_valid, with no stalls.
- Throughput is 1 transaction per cycle.
- out_valid and c are driven directly from flops. in_ready is combinational from out_valid and out_ready.
- Output stability: c holds while out_valid && !out_ready.
- in_valid may drop without penalty.
- c is don't-care while out_valid is 0, but it must equal its reset value of 0 until the first valid result.

## Structure
- Package masked_gadget_pkg:
  - OP_AND / OP_XOR constants.
  - share_get / share_put slice functions.
  - NMUL = SHARES*SHARES helper.
  - SHARES range-check constants.
- Sub-module masked_refresh (WIDTH, SHARES): zero-sum refresh of one operand, combinational. Instantiated twice in stage 1, once for A and once for B.
- The remainder stays in masked_and_pipe: the stage registers, valid chain, stall logic and compression XOR trees.

## Test plan
- SHARES=2, WIDTH=8, op=AND; a=(0x3C,0x0F), b=(0x55,0xFF), all randomness 0 -> 3 cycles later out_valid=1 and c0^c1 = 0x22.
- Same operands with r_ref=(0xA5,0x5A) and r_mul=(0x11,0x22,0x44,0x88) -> c0^c1 = 0x22 and c1 = 0x11^0x22^0x44^0x88 = 0xFF.
- Back-to-back streaming of 8 random vectors with out_ready held at 1 -> 8 consecutive out_valid cycles, and each result is correct.
- Backpressure: out_ready low for 2 cycles while a result is valid -> c and out_valid held, in_ready=0; the result is released in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 2 transactions in flight -> out_valid=0 and c=0 next cycle; no stale result appears afterwards.
- SHARES=3, op=XOR; a XOR-value 0xF0, b XOR-value 0x3C, random refresh -> XOR of the 3 shares of c = 0xCC.

Source files
------------

// File: rtl/masked_gadget_pkg.sv
// Shared constants and share-slicing helpers for the masked gadget datapath.
// Share helpers work on a fixed maximum-width bus; callers zero-extend/truncate with casts.
package masked_gadget_pkg;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_XOR = 1'b1;

    localparam int SHARES_MIN = 2;
    localparam int SHARES_MAX = 4;
    localparam int MAX_WIDTH  = 64;
    localparam int MAX_BUS    = SHARES_MAX * SHARES_MAX * MAX_WIDTH;

    typedef logic [MAX_BUS-1:0]   bus_t;
    typedef logic [MAX_WIDTH-1:0] word_t;

    function automatic int nmul(input int shares);
        return shares * shares;
    endfunction

    function automatic word_t share_get(input bus_t bus, input int idx, input int width);
        word_t mask;
        mask = '1;
        mask = mask >> (MAX_WIDTH - width);
        return word_t'(bus >> (idx * width)) & mask;
    endfunction

    function automatic bus_t share_put(input bus_t bus, input int idx, input int width,
                                       input word_t val);
        word_t mask;
        bus_t  clr;
        mask = '1;
        mask = mask >> (MAX_WIDTH - width);
        clr  = bus_t'(mask) << (idx * width);
        return (bus & ~clr) | (bus_t'(val & mask) << (idx * width));
    endfunction

endpackage

// File: rtl/masked_refresh.sv
// Zero-sum refresh of one shared operand: shares 0..d-2 take a fresh mask each,
// the last share absorbs the XOR of all masks so the recombined value is unchanged.
module masked_refresh
    import masked_gadget_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SHARES = 2
) (
    input  logic [SHARES*WIDTH-1:0]     x,
    input  logic [(SHARES-1)*WIDTH-1:0] r,
    output logic [SHARES*WIDTH-1:0]     y
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = '0;
        y   = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            acc = acc ^ WIDTH'(share_get(bus_t'(r), i, WIDTH));
            y[i*WIDTH +: WIDTH] = WIDTH'(share_get(bus_t'(x), i, WIDTH))
                                ^ WIDTH'(share_get(bus_t'(r), i, WIDTH));
        end
        y[(SHARES-1)*WIDTH +: WIDTH] = WIDTH'(share_get(bus_t'(x), SHARES - 1, WIDTH)) ^ acc;
    end

endmodule

// File: rtl/masked_and_pipe.sv
// d-share masked AND/XOR gadget: refresh -> masked products -> compression, three
// registered stages advancing as one unit under a single stall signal.
module masked_and_pipe
    import masked_gadget_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SHARES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                op,
    input  logic [SHARES*WIDTH-1:0]             a,
    input  logic [SHARES*WIDTH-1:0]             b,
    input  logic [2*(SHARES-1)*WIDTH-1:0]       r_ref,
    input  logic [SHARES*SHARES*WIDTH-1:0]      r_mul,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SHARES*WIDTH-1:0]             c
);

    localparam int NM = nmul(SHARES);
    localparam int SW = SHARES * WIDTH;
    localparam int KW = (SHARES - 1) * WIDTH;

    if (SHARES < SHARES_MIN || SHARES > SHARES_MAX) begin : g_bad_shares
        $error("masked_and_pipe: SHARES must be in 2..4");
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("masked_and_pipe: WIDTH must be in 1..64");
    end

    // Handshake: a beat moves on a rising edge where valid && ready. out_valid/c hold
    // until out_ready; while the output is blocked the whole pipe freezes and in_ready=0.
    logic stall;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    logic [SW-1:0] a_ref, b_ref;

    masked_refresh #(.WIDTH(WIDTH), .SHARES(SHARES)) u_refresh_a (
        .x (a),
        .r (r_ref[0 +: KW]),
        .y (a_ref)
    );

    masked_refresh #(.WIDTH(WIDTH), .SHARES(SHARES)) u_refresh_b (
        .x (b),
        .r (r_ref[KW +: KW]),
        .y (b_ref)
    );

    logic              v1, v2;
    logic [SW-1:0]     a1, b1;
    logic [NM*WIDTH-1:0] rm1;
    logic              op1, op2;
    logic [NM*WIDTH-1:0] p_d, p2;
    logic [KW-1:0]     k_d, k2;
    logic [SW-1:0]     c_d;

    // Products and mask compressions; in XOR mode only the diagonal carries data.
    always_comb begin
        p_d = '0;
        k_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                if (op1 == OP_AND) begin
                    p_d[(i*SHARES+j)*WIDTH +: WIDTH] =
                        (a1[i*WIDTH +: WIDTH] & b1[j*WIDTH +: WIDTH])
                        ^ rm1[(i*SHARES+j)*WIDTH +: WIDTH];
                end else if (i == j) begin
                    p_d[(i*SHARES+j)*WIDTH +: WIDTH] =
                        a1[i*WIDTH +: WIDTH] ^ b1[j*WIDTH +: WIDTH];
                end
            end
        end
        if (op1 == OP_AND) begin
            for (int m = 0; m < NM; m++) begin
                k_d[(m % (SHARES-1))*WIDTH +: WIDTH] =
                    k_d[(m % (SHARES-1))*WIDTH +: WIDTH] ^ rm1[m*WIDTH +: WIDTH];
            end
        end
    end

    // Every mask word lands once in c_0 (via p) and once in some c_s (via k), so they cancel.
    always_comb begin
        c_d = '0;
        if (op2 == OP_AND) begin
            for (int m = 0; m < NM; m++) begin
                c_d[0 +: WIDTH] = c_d[0 +: WIDTH] ^ p2[m*WIDTH +: WIDTH];
            end
            for (int s = 1; s < SHARES; s++) begin
                c_d[s*WIDTH +: WIDTH] = k2[(s-1)*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < SHARES; i++) begin
                c_d[i*WIDTH +: WIDTH] = p2[(i*SHARES+i)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            rm1       <= '0;
            op1       <= 1'b0;
            op2       <= 1'b0;
            p2        <= '0;
            k2        <= '0;
            c         <= '0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                a1  <= a_ref;
                b1  <= b_ref;
                rm1 <= r_mul;
                op1 <= op;
            end
            v2 <= v1;
            if (v1) begin
                p2  <= p_d;
                k2  <= k_d;
                op2 <= op1;
            end
            out_valid <= v2;
            if (v2) begin
                c <= c_d;
            end
        end
    end

endmodule

// File: tb/tb_masked_and_pipe.sv
// Directed bench for masked_and_pipe: a 2-share instance for the main scenarios and a
// 3-share instance for the generalised share count.
module tb_masked_and_pipe;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [15:0] a, b, r_ref, c;
    logic [31:0] r_mul;

    logic        in_valid3, in_ready3, op3, out_valid3, out_ready3;
    logic [23:0] a3, b3, c3;
    logic [31:0] r_ref3;
    logic [71:0] r_mul3;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    masked_and_pipe #(.WIDTH(8), .SHARES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .r_ref(r_ref), .r_mul(r_mul),
        .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    masked_and_pipe #(.WIDTH(8), .SHARES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .op(op3),
        .a(a3), .b(b3), .r_ref(r_ref3), .r_mul(r_mul3),
        .out_valid(out_valid3), .out_ready(out_ready3), .c(c3)
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 1'b0; op = 1'b0; a = '0; b = '0; r_ref = '0; r_mul = '0; out_ready = 1'b1;
        in_valid3 = 1'b0; op3 = 1'b0; a3 = '0; b3 = '0; r_ref3 = '0; r_mul3 = '0;
        out_ready3 = 1'b1;
    endtask

    // Presents one beat on the 2-share instance; returns on the negedge after acceptance.
    task automatic send(input logic o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] rr, input logic [31:0] rm);
        @(negedge clk);
        op = o; a = av; b = bv; r_ref = rr; r_mul = rm; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic o, input logic [23:0] av, input logic [23:0] bv,
                         input logic [31:0] rr, input logic [71:0] rm);
        @(negedge clk);
        op3 = o; a3 = av; b3 = bv; r_ref3 = rr; r_mul3 = rm; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || c !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: out_valid=%0b c=%h want 0/0000", out_valid, c);
        end
        checks++;
        if (out_valid3 !== 1'b0 || c3 !== 24'h0) begin
            errors++;
            $display("FAIL reset_out3: out_valid=%0b c=%h want 0/000000", out_valid3, c3);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b/%0b want 1/1", in_ready, in_ready3);
        end
    endtask

    task automatic test_and_basic();
        int lat;
        send(1'b0, 16'h0F3C, 16'hFF55, 16'h0000, 32'h0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL and_basic_latency: got %0d want 3", lat); end
        checks++;
        if ((c[7:0] ^ c[15:8]) !== 8'h22) begin
            errors++; $display("FAIL and_basic_value: got %h want 22", c[7:0] ^ c[15:8]);
        end
        checks++;
        if (c !== 16'h0022) begin errors++; $display("FAIL and_basic_shares: got %h want 0022", c); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL and_basic_drain: out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_and_masked();
        int lat;
        send(1'b0, 16'h0F3C, 16'hFF55, 16'h5AA5, 32'h88442211);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL and_masked_latency: got %0d want 3", lat); end
        checks++;
        if ((c[7:0] ^ c[15:8]) !== 8'h22) begin
            errors++; $display("FAIL and_masked_value: got %h want 22", c[7:0] ^ c[15:8]);
        end
        checks++;
        if (c[15:8] !== 8'hFF || c[7:0] !== 8'hDD) begin
            errors++; $display("FAIL and_masked_shares: got %h want FFDD", c);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa, xb, want;
        logic         want_v;
        int           nvalid;
        nvalid = 0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            want_v = (cyc >= 3 && cyc <= 10);
            checks++;
            if (out_valid !== want_v) begin
                errors++; $display("FAIL b2b_valid cyc %0d: got %0b want %0b", cyc, out_valid, want_v);
            end
            if (out_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra cyc %0d: got %h want none", cyc, c);
                end else begin
                    want = exp_q.pop_front();
                    if ((c[7:0] ^ c[15:8]) !== want) begin
                        errors++; $display("FAIL b2b_data cyc %0d: got %h want %h", cyc, c[7:0] ^ c[15:8], want);
                    end
                end
            end
            if (cyc < 8) begin
                op    = 1'($urandom_range(0, 1));
                a     = 16'($urandom_range(0, 16'hFFFF));
                b     = 16'($urandom_range(0, 16'hFFFF));
                r_ref = 16'($urandom_range(0, 16'hFFFF));
                r_mul = $urandom();
                xa = a[7:0] ^ a[15:8];
                xb = b[7:0] ^ b[15:8];
                exp_q.push_back(op ? (xa ^ xb) : (xa & xb));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (nvalid != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d results (%0d left) want 8 (0 left)", nvalid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        localparam int N = 5;
        logic [W-1:0] xa, xb;
        logic [15:0]  c_hold;
        int sent, got, stalls, extra;
        sent = 0; got = 0; stalls = 0; extra = 0; c_hold = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < 40 && got < N; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc == 3 || cyc == 4);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready cyc %0d: got %0b want %0b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (cyc == 3) c_hold = c;
            if (cyc == 4 || cyc == 5) begin
                checks++;
                if (out_valid !== 1'b1 || c !== c_hold) begin
                    errors++; $display("FAIL bp_hold cyc %0d: got %0b/%h want 1/%h", cyc, out_valid, c, c_hold);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra cyc %0d: got %h want none", cyc, c);
                end else if ((c[7:0] ^ c[15:8]) !== exp_q[0]) begin
                    errors++; $display("FAIL bp_data cyc %0d: got %h want %h", cyc, c[7:0] ^ c[15:8], exp_q[0]);
                end
                if (out_ready) begin
                    got++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    stalls++;
                end
            end
            if (sent < N && in_ready === 1'b1) begin
                op    = 1'b0;
                a     = 16'($urandom_range(0, 16'hFFFF));
                b     = 16'($urandom_range(0, 16'hFFFF));
                r_ref = 16'($urandom_range(0, 16'hFFFF));
                r_mul = $urandom();
                xa = a[7:0] ^ a[15:8];
                xb = b[7:0] ^ b[15:8];
                exp_q.push_back(xa & xb);
                in_valid = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != N || stalls != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d results %0d stalls want %0d results 2 stalls", got, stalls, N);
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL bp_duplicate: got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int spurious;
        spurious = 0;
        @(negedge clk);
        op = 1'b0; a = 16'h1234; b = 16'h5678; r_ref = 16'h9ABC; r_mul = 32'hDEADBEEF; in_valid = 1'b1;
        @(negedge clk);
        a = 16'hCAFE; b = 16'hF00D;
        @(negedge clk);
        rst_n = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || c !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_out: got %0b/%h want 0/0000", out_valid, c);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready); end
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || c !== 16'h0000) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d stale cycles want 0", spurious); end
    endtask

    task automatic test_xor3();
        int lat;
        logic [W-1:0] x;
        // a shares XOR to F0, b shares XOR to 3C
        send3(1'b1, 24'hD63412, 24'h5ACDAB, $urandom(), {8'($urandom()), $urandom(), $urandom()});
        lat = 1;
        while (out_valid3 !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        x = c3[7:0] ^ c3[15:8] ^ c3[23:16];
        checks++;
        if (lat != 3) begin errors++; $display("FAIL xor3_latency: got %0d want 3", lat); end
        checks++;
        if (x !== 8'hCC) begin errors++; $display("FAIL xor3_value: got %h want CC", x); end
        send3(1'b0, 24'hD63412, 24'h5ACDAB, $urandom(), {8'($urandom()), $urandom(), $urandom()});
        lat = 1;
        while (out_valid3 !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        x = c3[7:0] ^ c3[15:8] ^ c3[23:16];
        checks++;
        if (lat != 3 || x !== 8'h30) begin
            errors++; $display("FAIL and3_value: got %h lat %0d want 30 lat 3", x, lat);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_and_basic();
        test_and_masked();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_xor3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
